// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared 4x4 matrix constants, packing helper and streaming FSM states
package mat_pkg;

    localparam int MAT_DIM   = 4;
    localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } mat_state_e;

    // LSB offset of element [r][c]; [0][0] sits in the MSBs of the packed bus.
    function automatic int elem_lsb(input int r, input int c, input int elem_w);
        return elem_w * (MAT_ELEMS - 1 - (MAT_DIM * r + c));
    endfunction

endpackage

// File: rtl/mat_elem_sel.sv
// rtl/mat_elem_sel.sv - combinational 16:1 element mux over a packed 4x4 matrix
module mat_elem_sel
    import mat_pkg::*;
#(
    parameter int ELEM_W = 8
) (
    input  logic [MAT_ELEMS*ELEM_W-1:0] mat,
    input  logic [1:0]                  row,
    input  logic [1:0]                  col,
    output logic [ELEM_W-1:0]           elem
);

    always_comb begin
        elem = '0;
        for (int r = 0; r < MAT_DIM; r++) begin
            for (int c = 0; c < MAT_DIM; c++) begin
                if (row == r[1:0] && col == c[1:0]) begin
                    elem = mat[elem_lsb(r, c, ELEM_W) +: ELEM_W];
                end
            end
        end
    end

endmodule

// File: rtl/mat_stream_tx.sv
// rtl/mat_stream_tx.sv - captures a packed 4x4 matrix and streams it one tagged element per beat
module mat_stream_tx
    import mat_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [MAT_ELEMS*ELEM_W-1:0] in_mat,
    input  logic                        in_transpose,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [ELEM_W-1:0]           out_data,
    output logic [1:0]                  out_row,
    output logic [1:0]                  out_col,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic [CNT_W-1:0]            mat_count
);

    localparam int MAT_W = MAT_ELEMS * ELEM_W;

    mat_state_e       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [MAT_W-1:0] hold_q, hold_d;
    logic             tr_q, tr_d;
    logic [CNT_W-1:0] mat_count_q, mat_count_d;

    logic out_fire;
    logic in_fire;

    always_comb begin
        out_valid = (state_q == STREAM);
        out_last  = out_valid && (idx_q == 4'hF);
        out_fire  = out_valid && out_ready;
        // Refilling on the final beat keeps consecutive matrices bubble-free.
        in_ready  = !out_valid || (out_fire && out_last);
        in_fire   = in_valid && in_ready;
        busy      = out_valid;
        mat_count = mat_count_q;
        out_row   = tr_q ? idx_q[1:0] : idx_q[3:2];
        out_col   = tr_q ? idx_q[3:2] : idx_q[1:0];
    end

    mat_elem_sel #(
        .ELEM_W (ELEM_W)
    ) u_elem_sel (
        .mat  (hold_q),
        .row  (out_row),
        .col  (out_col),
        .elem (out_data)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        tr_d        = tr_q;
        mat_count_d = mat_count_q;
        if (out_fire) begin
            idx_d = idx_q + 4'd1;
            if (out_last) begin
                mat_count_d = mat_count_q + 1'b1;
                state_d     = IDLE;
            end
        end
        if (in_fire) begin
            hold_d  = in_mat;
            tr_d    = in_transpose;
            idx_d   = 4'd0;
            state_d = STREAM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            hold_q      <= '0;
            tr_q        <= 1'b0;
            mat_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            tr_q        <= tr_d;
            mat_count_q <= mat_count_d;
        end
    end

endmodule

// File: tb/tb_mat_stream_tx.sv
// tb/tb_mat_stream_tx.sv - directed self-checking bench for mat_stream_tx
module tb_mat_stream_tx;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_mat;
    logic         in_transpose;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic [1:0]   out_row;
    logic [1:0]   out_col;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic [15:0]  mat_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_count = 16'd0;

    mat_stream_tx #(.ELEM_W(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_mat       (in_mat),
        .in_transpose (in_transpose),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .mat_count    (mat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] make_mat(input logic [7:0] base);
        logic [127:0] m;
        m = '0;
        for (int k = 0; k < 16; k++) m[127-8*k -: 8] = base + 8'(k);
        return m;
    endfunction

    task automatic test_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_checks++; if (out_row !== 2'd0 || out_col !== 2'd0) begin n_fail++; $display("FAIL reset_tags got %0d,%0d want 0,0", out_row, out_col); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (mat_count !== 16'd0) begin n_fail++; $display("FAIL reset_mat_count got %0d want 0", mat_count); end
    endtask

    // Called at a negedge while idle; returns at the negedge after the capture edge.
    task automatic send_matrix(input logic [7:0] base, input bit tr);
        in_mat       = make_mat(base);
        in_transpose = tr;
        in_valid     = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL send_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Walks the 16 beats of one matrix; stall applies the 1,0,0,1 out_ready pattern.
    task automatic stream_check(input logic [7:0] base, input bit tr, input bit stall, input string name);
        int i;
        int cyc;
        logic [1:0] er, ec;
        i   = 0;
        cyc = 0;
        while (i < 16 && cyc < 100) begin
            out_ready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            #1;
            er = tr ? i[1:0] : i[3:2];
            ec = tr ? i[3:2] : i[1:0];
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid beat %0d got %b want 1", name, i, out_valid); end
            n_checks++; if (out_data !== base + 8'(4*er + ec)) begin n_fail++; $display("FAIL %s_data beat %0d got %h want %h", name, i, out_data, base + 8'(4*er + ec)); end
            n_checks++; if (out_row !== er || out_col !== ec) begin n_fail++; $display("FAIL %s_tags beat %0d got %0d,%0d want %0d,%0d", name, i, out_row, out_col, er, ec); end
            n_checks++; if (out_last !== (i == 15)) begin n_fail++; $display("FAIL %s_last beat %0d got %b want %b", name, i, out_last, i == 15); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy beat %0d got %b want 1", name, i, busy); end
            n_checks++; if (in_ready !== (i == 15 && out_ready)) begin n_fail++; $display("FAIL %s_in_ready beat %0d got %b want %b", name, i, in_ready, i == 15 && out_ready); end
            if (out_ready) i++;
            cyc++;
            @(negedge clk);
        end
        n_checks++; if (i != 16) begin n_fail++; $display("FAIL %s_timeout accepted %0d beats want 16", name, i); end
        exp_count = exp_count + 16'd1;
        out_ready = 1'b1;
    endtask

    task automatic check_idle(input string name);
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle got valid=%b busy=%b want 0,0", name, out_valid, busy); end
        n_checks++; if (mat_count !== exp_count) begin n_fail++; $display("FAIL %s_count got %0d want %0d", name, mat_count, exp_count); end
    endtask

    task automatic test_single();
        send_matrix(8'h00, 1'b0);
        stream_check(8'h00, 1'b0, 1'b0, "single");
        check_idle("single");
    endtask

    task automatic test_transpose();
        send_matrix(8'h00, 1'b1);
        stream_check(8'h00, 1'b1, 1'b0, "transpose");
        check_idle("transpose");
    endtask

    task automatic test_backpressure();
        send_matrix(8'h00, 1'b0);
        stream_check(8'h00, 1'b0, 1'b1, "stall");
        check_idle("stall");
    endtask

    task automatic test_back_to_back();
        send_matrix(8'h10, 1'b0);
        in_valid = 1'b1;
        in_mat   = make_mat(8'h20);
        stream_check(8'h10, 1'b0, 1'b0, "b2b_first");
        in_valid = 1'b0;
        stream_check(8'h20, 1'b0, 1'b0, "b2b_second");
        check_idle("b2b");
    endtask

    task automatic test_reset_midstream();
        send_matrix(8'h30, 1'b0);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_count = 16'd0;
        n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL midreset_out got valid=%b last=%b want 0,0", out_valid, out_last); end
        n_checks++; if (mat_count !== 16'd0) begin n_fail++; $display("FAIL midreset_count got %0d want 0", mat_count); end
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_ready got in_ready=%b busy=%b want 1,0", in_ready, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_matrix(8'h40, 1'b0);
        stream_check(8'h40, 1'b0, 1'b0, "after_reset");
        check_idle("after_reset");
    endtask

    task automatic test_count_wrap();
        force dut.mat_count_q = 16'hFFFF;
        #1;
        release dut.mat_count_q;
        #1;
        n_checks++; if (mat_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h want ffff", mat_count); end
        @(negedge clk);
        exp_count = 16'hFFFF;
        send_matrix(8'h50, 1'b1);
        stream_check(8'h50, 1'b1, 1'b0, "wrap");
        check_idle("wrap");
    endtask

    initial begin
        rst_n        = 1'b0;
        in_mat       = '0;
        in_transpose = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_single();
        test_transpose();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_stream_tx.md
Name: mat_stream_tx

Overview:
- Reader/transmitter for packed 4x4 matrix buses, e.g. the product bus of the combinational matrix multiplier in the graphics pipeline.
- Accepts one packed 16-element matrix per valid/ready handshake, holds it, and streams it out one element per accepted cycle with row/col tags and an end-of-matrix flag.
- Feeds serial consumers: the pixel/vertex transform stage and the UART/debug dump path.
- Optional per-matrix transpose, so column-major consumers need no second buffer.

Parameters:
- ELEM_W, 8: element width in bits.
- MAT_W, 16*ELEM_W: packed matrix width. Derived; not overridable.
- CNT_W, 16: width of the matrices-sent counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_mat  in  MAT_W  packed matrix. Element [r][c] occupies bits [MAT_W-1-ELEM_W*(4r+c) -: ELEM_W], so [0][0] is in the MSBs and [3][3] in the LSBs.
- in_transpose  in  1  sampled with in_mat at handshake; 1 = stream column-major.
- in_valid  in  1  producer has a matrix.
- in_ready  out  1  block can capture a matrix this cycle.
- out_data  out  ELEM_W  current element.
- out_row  out  2  row index of out_data in the original matrix.
- out_col  out  2  column index of out_data in the original matrix.
- out_last  out  1  out_data is the 16th element of the matrix.
- out_valid  out  1  out_data and tags are valid.
- out_ready  in  1  consumer accepts the element.
- busy  out  1  a matrix is held and not fully sent.
- mat_count  out  CNT_W  number of matrices fully sent; wraps.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state IDLE, idx=0, hold register=0, transpose flag=0, mat_count=0.
  - Outputs: out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, busy=0, in_ready=1.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - STREAM: out_valid=1.
- Capture: an input handshake (in_valid & in_ready) registers in_mat and in_transpose, sets idx=0 and moves to STREAM. The first element is valid on the next cycle, so latency is 1 cycle from handshake to first out_valid.
- Element order, for idx=0..15:
  - transpose=0: row = idx[3:2], col = idx[1:0].
  - transpose=1: row = idx[1:0], col = idx[3:2].
  - out_data = element[row][col] of the hold register. out_data, out_row and out_col are decoded combinationally from registered state only; there is no combinational path from the input side to the output side.
- Output handshake (out_valid & out_ready): idx increments. Without it, out_data, tags and out_last stay stable and idx does not change.
- out_last = (idx==15) in STREAM.
- Last element accepted:
  - mat_count increments, wrapping from 2^CNT_W-1 to 0.
  - If in_valid is also high in that cycle, the new matrix is captured in the same cycle: state stays STREAM, idx=0, and there are no bubbles between matrices.
  - Otherwise the state goes to IDLE.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is a combinational path from out_ready to in_ready and is intended.
- in_valid while STREAMing and not on the last accepted element: ignored. in_ready=0, so the producer must hold the matrix.
- busy = (state==STREAM).
- Reset mid-stream: the in-flight matrix is discarded, mat_count is cleared and no partial out_last is emitted.
- Arithmetic: no computation. Elements pass through bit-exact, with no sign or width conversion.

Decomposition:
- Shared package mat_pkg:
  - MAT_DIM=4 and MAT_ELEMS=16.
  - Element-index helper function (r,c) -> bit offset, reused by the multiplier and any future matrix blocks.
  - State enum {IDLE, STREAM}.
- One sub-module, mat_elem_sel: combinational 16:1 element mux taking the packed matrix, row and col. It is the inverse of the packing used by the multiplier and is reusable by a future element-wise loader.

Test Plan:
- Single matrix, transpose=0: in_mat elements = 0x00..0x0F ([0][0]=0x00), out_ready held 1 -> out_data 0x00,0x01,...,0x0F on 16 consecutive cycles starting 1 cycle after handshake; out_last only on 0x0F; mat_count=1; busy returns to 0.
- Same matrix, transpose=1 -> out_data 0x00,0x04,0x08,0x0C,0x01,...,0x0F; out_row/out_col report original indices, e.g. the 2nd element has row=1, col=0.
- Backpressure: out_ready toggled 1,0,0,1,... -> no element lost or duplicated; data and tags stable while stalled; sequence identical to the first test.
- Back-to-back: two matrices (0x10..0x1F, then 0x20..0x2F) with in_valid held -> second captured on the cycle 0x1F is accepted; 32 contiguous valid cycles; in_ready=0 during elements 0..14 of the first matrix; mat_count=2.
- Reset mid-stream: assert rst_n=0 after 5 elements -> out_valid drops immediately, mat_count=0, in_ready=1; the next matrix streams from idx 0.
- Counter wrap: force or preload 65535 completed matrices (CNT_W=16) -> mat_count wraps to 0 on the next completion.
